// File: rtl/conv_window_seq_if.sv
// Handshake and memory-side bundle for the convolution window sequencer.
// The master side is the sequencer; the slave side is the pixel source / MAC environment.
interface conv_window_seq_if;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        mem_we;
    logic [15:0] mem_data_in;
    logic [15:0] mem_addr_write;
    logic [15:0] mem_addr_read;
    logic        tap_valid;
    logic        tap_ready;
    logic        tap_first;
    logic        tap_last;
    logic        busy;
    logic        done;

    modport master (
        input  start, in_valid, in_data, tap_ready,
        output in_ready, mem_we, mem_data_in, mem_addr_write,
        output mem_addr_read, tap_valid, tap_first, tap_last,
        output busy, done
    );

    modport slave (
        output start, in_valid, in_data, tap_ready,
        input  in_ready, mem_we, mem_data_in, mem_addr_write,
        input  mem_addr_read, tap_valid, tap_first, tap_last,
        input  busy, done
    );
endinterface

// File: rtl/conv_window_seq.sv
// Loads a ROWxCOL feature map into array memory, then walks every KxK
// window in raster order, issuing one read-address tap per handshake.
module conv_window_seq #(
    parameter int ROW = 8,
    parameter int COL = 8,
    parameter int K   = 3
) (
    input logic               clk,
    input logic               rst_n,
    conv_window_seq_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCAN,
        DONE
    } state_t;

    localparam logic [7:0] ROW_M1 = 8'(ROW - 1);
    localparam logic [7:0] COL_M1 = 8'(COL - 1);
    localparam logic [7:0] K_M1   = 8'(K - 1);
    localparam logic [7:0] WR_MAX = 8'(ROW - K);
    localparam logic [7:0] WC_MAX = 8'(COL - K);

    state_t     state_q, state_d;
    logic [7:0] r_q, r_d;
    logic [7:0] c_q, c_d;
    logic [7:0] wr_q, wr_d;
    logic [7:0] wc_q, wc_d;
    logic [7:0] kr_q, kr_d;
    logic [7:0] kc_q, kc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            c_q     <= '0;
            wr_q    <= '0;
            wc_q    <= '0;
            kr_q    <= '0;
            kc_q    <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            wr_q    <= wr_d;
            wc_q    <= wc_d;
            kr_q    <= kr_d;
            kc_q    <= kc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        wr_d    = wr_q;
        wc_d    = wc_q;
        kr_d    = kr_q;
        kc_d    = kc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    r_d     = '0;
                    c_d     = '0;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    if (c_q == COL_M1) begin
                        c_d = '0;
                        if (r_q == ROW_M1) begin
                            r_d     = '0;
                            state_d = SCAN;
                        end else begin
                            r_d = r_q + 8'd1;
                        end
                    end else begin
                        c_d = c_q + 8'd1;
                    end
                end
            end
            SCAN: begin
                // Tap counters roll into the window counters; the
                // whole chain leaves every counter at zero on exit.
                if (bus.tap_ready) begin
                    if (kc_q != K_M1) begin
                        kc_d = kc_q + 8'd1;
                    end else begin
                        kc_d = '0;
                        if (kr_q != K_M1) begin
                            kr_d = kr_q + 8'd1;
                        end else begin
                            kr_d = '0;
                            if (wc_q != WC_MAX) begin
                                wc_d = wc_q + 8'd1;
                            end else begin
                                wc_d = '0;
                                if (wr_q != WR_MAX) begin
                                    wr_d = wr_q + 8'd1;
                                end else begin
                                    wr_d    = '0;
                                    state_d = DONE;
                                end
                            end
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    logic       in_load;
    logic       in_scan;
    logic [7:0] rd_row;
    logic [7:0] rd_col;

    assign in_load = (state_q == LOAD);
    assign in_scan = (state_q == SCAN);
    assign rd_row  = wr_q + kr_q;
    assign rd_col  = wc_q + kc_q;

    assign bus.in_ready       = in_load;
    assign bus.mem_we         = in_load && bus.in_valid;
    assign bus.mem_data_in    = bus.in_data;
    assign bus.mem_addr_write = {r_q, c_q};
    assign bus.mem_addr_read  = {rd_row, rd_col};
    assign bus.tap_valid      = in_scan;
    assign bus.tap_first      = in_scan && (kr_q == 8'd0) && (kc_q == 8'd0);
    assign bus.tap_last       = in_scan && (kr_q == K_M1) && (kc_q == K_M1);
    assign bus.busy           = (state_q != IDLE);
    assign bus.done           = (state_q == DONE);

endmodule

// File: doc/conv_window_seq.md
CONV_WINDOW_SEQ -- requirements
Module: conv_window_seq

Interface
REQ-001 SHALL have parameter ROW, default 8, feature-map rows held in the array memory (1..256).
REQ-002 SHALL have parameter COL, default 8, feature-map columns held in the array memory (1..256).
REQ-003 SHALL have parameter K, default 3, square kernel size; K<=ROW and K<=COL.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a load+scan job.
REQ-007 SHALL have port in_valid  input  1  input pixel valid.
REQ-008 SHALL have port in_data  input  16  input pixel, signed.
REQ-009 SHALL have port in_ready  output  1  pixel accepted when in_valid&&in_ready.
REQ-010 SHALL have port mem_we  output  1  array-memory write enable.
REQ-011 SHALL have port mem_data_in  output  16  array-memory write data.
REQ-012 SHALL have port mem_addr_write  output  16  write address {row[7:0],col[7:0]}.
REQ-013 SHALL have port mem_addr_read  output  16  read address {row[7:0],col[7:0]}.
REQ-014 SHALL have port tap_valid  output  1  mem_addr_read holds a valid kernel tap.
REQ-015 SHALL have port tap_ready  input  1  downstream MAC accepts tap when tap_valid&&tap_ready.
REQ-016 SHALL have port tap_first  output  1  current tap is (0,0) of its window.
REQ-017 SHALL have port tap_last  output  1  current tap is (K-1,K-1) of its window.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.
REQ-019 SHALL have port done  output  1  one-cycle pulse at job completion.

Function
REQ-020 SHALL implement states IDLE, LOAD, SCAN, DONE.
REQ-021 IDLE: start=1 SHALL move to LOAD next cycle; load counters (r,c) cleared to (0,0).
REQ-022 LOAD: in_ready SHALL be 1; mem_we, mem_data_in, mem_addr_write combinational: mem_we=in_valid, mem_data_in=in_data, mem_addr_write={r,c}.
REQ-023 LOAD: each accepted pixel SHALL advance raster order, c increments, c=COL-1 wraps to 0 with r+1.
REQ-024 LOAD: accepting pixel (ROW-1,COL-1) SHALL move to SCAN next cycle; no further in_ready.
REQ-025 In IDLE, SCAN, DONE, in_ready and mem_we SHALL be 0; mem_data_in/mem_addr_write don't-care.
REQ-026 SCAN: tap_valid SHALL be 1 from the first SCAN cycle; window origin (wr,wc) and tap (kr,kc) start at 0.
REQ-027 SCAN: mem_addr_read SHALL equal {wr+kr, wc+kc} (8-bit fields, no overflow given parameter limits).
REQ-028 SCAN: on tap_valid&&tap_ready, kc SHALL increment; kc=K-1 wraps with kr+1; kr=K-1,kc=K-1 wraps tap to (0,0) and advances window.
REQ-029 Window advance SHALL be raster: wc increments to COL-K, then wraps to 0 with wr+1, up to ROW-K.
REQ-030 tap_valid&&!tap_ready SHALL hold mem_addr_read, tap_first, tap_last, and all counters stable.
REQ-031 Handshake on last tap of window (ROW-K,COL-K) SHALL move to DONE; tap_valid 0 in DONE.
REQ-032 DONE: done=1 for exactly one cycle, then IDLE.
REQ-033 start SHALL be ignored outside IDLE.
REQ-034 Total taps per job SHALL be (ROW-K+1)*(COL-K+1)*K*K; writes per job ROW*COL.
REQ-035 K=ROW=COL SHALL produce a single window of K*K taps.

Reset
REQ-036 rst_n=0 SHALL asynchronously force IDLE, all counters 0, in_ready=0, mem_we=0, tap_valid=0, tap_first=0, tap_last=0, busy=0, done=0, mem_addr_read=0.
REQ-037 Reset mid-LOAD or mid-SCAN SHALL abandon the job; first cycle after release is IDLE, start required to restart.

Verification
REQ-038 Reset: assert rst_n=0 mid-SCAN -> all outputs 0 same cycle; after release busy=0 until start.
REQ-039 Load: defaults, start, 64 pixels with in_valid gaps -> exactly 64 mem_we pulses, last at addr 0x0707, SCAN next cycle.
REQ-040 First windows, tap_ready=1: taps 0x0000,0x0001,0x0002,0x0100..0x0202 with tap_first on 0x0000, tap_last on 0x0202; next tap 0x0001 with tap_first.
REQ-041 Stall: hold tap_ready=0 for 5 cycles on tap 0x0101 -> address and flags unchanged, counters frozen, resumes at 0x0102.
REQ-042 Completion: full run -> 324 tap handshakes, final tap 0x0707 with tap_last, done one cycle later for one cycle, start pulses during busy have no effect.
REQ-043 Degenerate: ROW=COL=K=3 -> 9 writes, 9 taps 0x0000..0x0202, single tap_first and tap_last.
